// File: rtl/cdb_pkg.sv
// Common data bus definitions shared by the CDB arbiter and its consumers.
// Holds the reservation-station tag encoding and the bus widths.
package cdb_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 64;

    typedef enum logic [TAG_W-1:0] {
        notag  = 4'd0,
        add_1  = 4'd1,
        add_2  = 4'd2,
        add_3  = 4'd3,
        mult_1 = 4'd4,
        mult_2 = 4'd5,
        ld_1   = 4'd6,
        ld_2   = 4'd7,
        ld_3   = 4'd8,
        st_1   = 4'd9,
        st_2   = 4'd10
    } cdb_tag_e;

    // Requester slot i broadcasts tag i+1; tag 0 is reserved for an empty bus cycle.
    function automatic logic [TAG_W-1:0] idx_to_tag(input int unsigned idx);
        return TAG_W'(idx + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request at or after rr_ptr, wrapping.
// Purely combinational; produces a one-hot grant plus its binary index.
module rr_priority_picker #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    logic [IDX_W-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        sel       = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sel = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (enable && !grant_vld && req[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one result producer per cycle round-robin
// and registers the winning tag/value onto the CDB for the ROB and stations.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int TAG_W   = cdb_pkg::TAG_W,
    parameter int DATA_W  = cdb_pkg::DATA_W,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      CTRL_flush,
    output logic [NUM_REQ-1:0]        grant,
    output logic [TAG_W-1:0]          cdb_id,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [CNT_W-1:0]          conflict_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant_vld;
    logic              pick_en;
    logic [DATA_W-1:0] win_data;
    logic [IDX_W-1:0]  next_ptr;
    logic              contended;

    // Reset and flush both suppress the grant so nothing is accepted from requesters.
    assign pick_en   = rst_n && !CTRL_flush;
    assign win_data  = req_data[grant_idx*DATA_W +: DATA_W];
    assign next_ptr  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign contended = ($countones(req) >= 2) && !CTRL_flush;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .enable    (pick_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_id   <= '0;
            cdb_data <= '0;
            rr_ptr   <= '0;
        end else if (grant_vld) begin
            cdb_id   <= TAG_W'(idx_to_tag(int'(grant_idx)));
            cdb_data <= win_data;
            rr_ptr   <= next_ptr;
        end else begin
            cdb_id   <= TAG_W'(notag);
            cdb_data <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (contended && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference round-robin model queues the
// expected broadcast for each cycle, which is compared one edge later.
module tb_cdb_arbiter;

    localparam int NR = 8;
    localparam int DW = 64;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic              CTRL_flush;
    logic [NR-1:0]     grant;
    logic [3:0]        cdb_id;
    logic [DW-1:0]     cdb_data;
    logic [15:0]       conflict_cnt;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   m_ptr;
    logic [15:0] m_cnt;
    int   n_checks;
    int   n_fail;

    cdb_arbiter u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .CTRL_flush   (CTRL_flush),
        .grant        (grant),
        .cdb_id       (cdb_id),
        .cdb_data     (cdb_data),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [7:0] r, input int p);
        for (int o = 0; o < NR; o++) begin
            if (r[(p + o) % NR]) return (p + o) % NR;
        end
        return -1;
    endfunction

    // Called just after a rising edge; drives one cycle and checks the resulting broadcast.
    task automatic cycle(input logic [7:0] r, input logic fl, input logic [NR*DW-1:0] d);
        exp_t e;
        int   k;
        logic [7:0] g_exp;
        req        = r;
        CTRL_flush = fl;
        req_data   = d;
        #2;
        k     = fl ? -1 : model_pick(r, m_ptr);
        g_exp = (k >= 0) ? (8'd1 << k) : 8'd0;
        check("grant", 64'(grant), 64'(g_exp));
        if (k >= 0) begin
            e.id   = 4'(k + 1);
            e.data = d[k*DW +: DW];
            m_ptr  = (k + 1) % NR;
        end else begin
            e.id   = 4'd0;
            e.data = 64'd0;
        end
        if (($countones(r) >= 2) && !fl && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("cdb_id", 64'(cdb_id), 64'(e.id));
            check("cdb_data", cdb_data, e.data);
        end
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    // Asserts reset away from the clock edge, checks outputs, then releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_cdb_id", 64'(cdb_id), 64'd0);
        check("rst_cdb_data", cdb_data, 64'd0);
        check("rst_cnt", 64'(conflict_cnt), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        sb.delete();
        m_ptr = 0;
        m_cnt = 16'd0;
        @(posedge clk);
        #1;
        check("rst_hold_id", 64'(cdb_id), 64'd0);
        req        = '0;
        CTRL_flush = 1'b0;
        rst_n      = 1'b1;
    endtask

    logic [NR*DW-1:0] d_idx;
    logic [NR*DW-1:0] d0;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        req        = '0;
        req_data   = '0;
        CTRL_flush = 1'b0;
        m_ptr      = 0;
        m_cnt      = 16'd0;
        for (int i = 0; i < NR; i++) d_idx[i*DW +: DW] = 64'(i);
        d0 = '0;
        d0[63:0] = 64'h1234;

        @(posedge clk);
        #1;
        do_reset();

        // Single requester, then idle.
        cycle(8'h01, 1'b0, d0);
        check("t1_id", 64'(cdb_id), 64'd1);
        check("t1_data", cdb_data, 64'h1234);
        cycle(8'h00, 1'b0, d0);
        check("t1_idle", 64'(cdb_id), 64'd0);

        // Round robin with everyone requesting from rr_ptr=0.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(8'hFF, 1'b0, d_idx);
            check("t2_seq", 64'(cdb_id), 64'((i % NR) + 1));
        end
        check("t2_cnt", 64'(conflict_cnt), 64'd9);

        // Move rr_ptr to 6, then the wrap case.
        cycle(8'h20, 1'b0, d_idx);
        cycle(8'h81, 1'b0, d_idx);
        check("t3_first", 64'(cdb_id), 64'd8);
        cycle(8'h01, 1'b0, d_idx);
        check("t3_second", 64'(cdb_id), 64'd1);

        // Flush cancels the cycle, then the held request competes.
        cycle(8'h24, 1'b1, d_idx);
        check("t4_flush_id", 64'(cdb_id), 64'd0);
        check("t4_flush_cnt", 64'(conflict_cnt), 64'd10);
        cycle(8'h24, 1'b0, d_idx);
        check("t4_after", 64'(cdb_id), 64'd3);
        cycle(8'h00, 1'b0, d_idx);

        // Stable single requester: back-to-back broadcasts.
        for (int i = 0; i < 3; i++) begin
            cycle(8'h08, 1'b0, d_idx);
            check("stable_id", 64'(cdb_id), 64'd4);
        end

        // Async reset while grant[4] is high: tag 5 must never appear.
        cycle(8'h02, 1'b0, d_idx);
        req        = 8'h10;
        CTRL_flush = 1'b0;
        #2;
        check("t5_grant", 64'(grant), 64'h10);
        do_reset();
        cycle(8'h11, 1'b0, d_idx);
        check("t5_ptr0", 64'(cdb_id), 64'd1);

        // Saturation of the conflict counter.
        do_reset();
        for (int i = 0; i < 65535; i++) cycle(8'h03, 1'b0, d_idx);
        check("t6_sat", 64'(conflict_cnt), 64'hFFFF);
        for (int i = 0; i < 4; i++) cycle(8'hFF, 1'b0, d_idx);
        check("t6_hold", 64'(conflict_cnt), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among the eight result-producing reservation-station tags: add_1..add_3, mult_1, mult_2 and ld_1..ld_3.
- Grants one requester per cycle with round-robin priority and registers the winning tag and data onto cdb_id/cdb_data.
- Those registered outputs feed the ROB and the reservation stations. Store tags (st_1, st_2) never broadcast, so they have no requester slot.
- On CTRL_flush it cancels the bus cycle and drives no tag.

Parameters:
- NUM_REQ, 8, number of requesters. Requester index i maps to tag i+1.
- TAG_W, 4, width of cdb_id.
- DATA_W, 64, width of cdb_data.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  request per tag. Bit 0=add_1, 1=add_2, 2=add_3, 3=mult_1, 4=mult_2, 5=ld_1, 6=ld_2, 7=ld_3.
- req_data  input  NUM_REQ*DATA_W  result per requester; slice i is bits [i*DATA_W +: DATA_W].
- CTRL_flush  input  1  mispredict flush from the ROB.
- grant  output  NUM_REQ  one-hot grant, combinational, same cycle as req.
- cdb_id  output  TAG_W  registered broadcast tag; 0 = notag.
- cdb_data  output  DATA_W  registered broadcast value.
- conflict_cnt  output  CNT_W  saturating count of cycles with two or more requests pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - cdb_id=0, cdb_data=0, conflict_cnt=0.
  - rr_ptr=0; grant is 0 while reset is asserted.
  - Reset mid-operation discards any grant in flight; requesters re-request after reset.
- Selection (combinational):
  - Scan req starting at index rr_ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit k wins and grant[k]=1. At most one grant bit is ever high.
  - If no requests are pending, or CTRL_flush=1, grant=0.
- Handshake:
  - A requester holds req high and req_data stable until it sees grant high at a rising edge.
  - It drops req the following cycle. Re-asserting req in that following cycle is legal and enters a new arbitration.
  - grant depends on req and never on req_data.
- Broadcast (registered, latency 1):
  - On the edge where grant[k]=1: cdb_id<=k+1, cdb_data<=req_data slice k, rr_ptr<=(k+1) mod NUM_REQ.
  - The winner becomes lowest priority next cycle.
  - Wrap-around: when k=7, rr_ptr<=0.
- Idle cycle (no grant, no flush): cdb_id<=0, cdb_data<=0, rr_ptr unchanged.
- Flush (CTRL_flush=1):
  - grant=0; on the next edge cdb_id<=0 and cdb_data<=0.
  - rr_ptr is unchanged and conflict_cnt does not increment.
  - Pending requests are not latched. The flushing reservation stations drop their own req.
  - If a requester keeps req high through the flush, it competes normally once flush drops.
- Conflict counter:
  - Increments on each edge where popcount(req)>=2 and CTRL_flush=0.
  - Saturates at all-ones and never wraps.
- Fairness: with all eight requesting continuously, each tag is granted exactly once in every 8 consecutive cycles.
- Stable requester: a single requester held high is granted every cycle, giving back-to-back broadcasts.

Decomposition:
- Shared package cdb_pkg holds:
  - tag constants notag=0, add_1=1, add_2=2, add_3=3, mult_1=4, mult_2=5, ld_1=6, ld_2=7, ld_3=8, st_1=9, st_2=10;
  - TAG_W and DATA_W;
  - the index-to-tag rule (tag = index+1).
- One sub-module, rr_priority_picker: inputs req vector, rr_ptr and enable; outputs one-hot grant and binary index. It is purely combinational and parameterised by NUM_REQ.
- The registers (cdb_id, cdb_data, rr_ptr, conflict_cnt) live in cdb_arbiter.

Test Plan:
1. Reset then a single requester: rst_n low→high, then req=8'b0000_0001 with slice0=64'h1234 for one cycle → grant=8'h01 that cycle; next cycle cdb_id=1, cdb_data=64'h1234; the cycle after, cdb_id=0.
2. Round-robin: req=8'hFF held for 9 cycles with slice i=i → cdb_id sequence 1,2,3,4,5,6,7,8,1; conflict_cnt=9.
3. Pointer wrap: with rr_ptr=6, req=8'b1000_0001 → grant bit7 (cdb_id=8) first, then bit0 (cdb_id=1).
4. Flush: req=8'h24 with CTRL_flush=1 → grant=0, next cdb_id=0, conflict_cnt unchanged; flush drops with req still 8'h24 → grant bit2 (cdb_id=3), assuming rr_ptr<=2.
5. Asynchronous reset mid-grant: grant[4]=1 and rst_n falls before the edge → cdb_id=0 immediately, rr_ptr=0, no broadcast of tag 5.
6. Saturation: preload via 65535 contended cycles → conflict_cnt=16'hFFFF and it stays there on further contention.
